// File: rtl/pulse_shape_upsampler_if.sv
// Bus bundles for the pulse-shape upsampler: AXI-Stream item port and CtrlPort slave.
interface pulse_shape_upsampler_axis_if #(
   parameter int unsigned ITEM_W = 32
);
   logic [ITEM_W-1:0] tdata;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tlast, output tvalid, input  tready);
   modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

interface pulse_shape_upsampler_ctrl_if;
   logic        req_wr;
   logic        req_rd;
   logic [19:0] req_addr;
   logic [31:0] req_data;
   logic        resp_ack;
   logic [31:0] resp_data;

   modport master (output req_wr, output req_rd, output req_addr, output req_data,
                   input  resp_ack, input resp_data);
   modport slave  (input  req_wr, input  req_rd, input  req_addr, input  req_data,
                   output resp_ack, output resp_data);
endinterface

// File: rtl/pulse_shape_upsampler.sv
// Upsamples sc16 symbols by SPS (zero-stuff or repeat) ahead of the RRC FIR.
// SPS/mode are programmed over CtrlPort and only take effect at a packet start.
module pulse_shape_upsampler #(
   parameter int unsigned ITEM_W      = 32,
   parameter int unsigned MAX_SPS     = 16,
   parameter int unsigned DEFAULT_SPS = 4,
   parameter logic [19:0] REG_BASE    = 20'h0
) (
   input  logic                               axis_data_clk,
   input  logic                               axis_data_rst,
   pulse_shape_upsampler_ctrl_if.slave        s_ctrlport,
   pulse_shape_upsampler_axis_if.slave        s_in,
   pulse_shape_upsampler_axis_if.master       m_out
);

   localparam int unsigned CNT_W     = $clog2(MAX_SPS + 1);
   localparam logic [19:0] ADDR_CTRL = REG_BASE;
   localparam logic [19:0] ADDR_PKT  = REG_BASE + 20'd4;

   typedef enum logic {ST_IDLE, ST_EMIT} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    phase_q, phase_d;
   logic [ITEM_W-1:0]   sample_q, sample_d;
   logic                last_q, last_d;
   logic                sop_q, sop_d;
   logic [CNT_W-1:0]    sps_act_q, sps_act_d;
   logic                mode_act_q, mode_act_d;
   logic [31:0]         pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0]    sps_reg_q, sps_reg_d;
   logic                mode_q, mode_d;
   logic                ack_q, ack_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                in_ready_c;
   logic                out_valid_c;
   logic                load_c;
   logic                sop_eff_c;
   logic                last_phase_c;
   logic [4:0]          wr_sps_c;
   logic                unused_ctrl_bits;

   assign last_phase_c = (phase_q == sps_act_q - CNT_W'(1));

   // Symbol sequencing; a back-to-back accept sees the sop value produced this cycle
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      sample_d    = sample_q;
      last_d      = last_q;
      sop_d       = sop_q;
      sps_act_d   = sps_act_q;
      mode_act_d  = mode_act_q;
      pkt_cnt_d   = pkt_cnt_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      load_c      = 1'b0;
      sop_eff_c   = sop_q;

      case (state_q)
         ST_IDLE: begin
            in_ready_c = 1'b1;
            load_c     = s_in.tvalid;
         end
         ST_EMIT: begin
            out_valid_c = 1'b1;
            if (m_out.tready) begin
               if (last_phase_c) begin
                  sop_d      = last_q;
                  sop_eff_c  = last_q;
                  in_ready_c = 1'b1;
                  load_c     = s_in.tvalid;
                  if (last_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
                  if (!s_in.tvalid) state_d = ST_IDLE;
               end else begin
                  phase_d = phase_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (axis_data_rst) begin
         in_ready_c  = 1'b0;
         out_valid_c = 1'b0;
         load_c      = 1'b0;
      end

      if (load_c) begin
         state_d  = ST_EMIT;
         phase_d  = '0;
         sample_d = s_in.tdata;
         last_d   = s_in.tlast;
         if (sop_eff_c) begin
            sps_act_d  = sps_reg_q;
            mode_act_d = mode_q;
         end
      end
   end

   // CtrlPort decode; out-of-range SPS writes keep the old SPS but still update MODE
   always_comb begin
      sps_reg_d = sps_reg_q;
      mode_d    = mode_q;
      ack_d     = s_ctrlport.req_wr | s_ctrlport.req_rd;
      rdata_d   = '0;
      wr_sps_c  = s_ctrlport.req_data[4:0];

      if (s_ctrlport.req_wr && s_ctrlport.req_addr == ADDR_CTRL) begin
         mode_d = s_ctrlport.req_data[8];
         if (wr_sps_c != 5'd0 && 32'(wr_sps_c) <= MAX_SPS) sps_reg_d = CNT_W'(wr_sps_c);
      end

      if (s_ctrlport.req_rd) begin
         if (s_ctrlport.req_addr == ADDR_CTRL)
            rdata_d = {23'd0, mode_q, 3'd0, 5'(sps_reg_q)};
         else if (s_ctrlport.req_addr == ADDR_PKT)
            rdata_d = pkt_cnt_q;
      end
   end

   assign unused_ctrl_bits = ^{s_ctrlport.req_data[31:9], s_ctrlport.req_data[7:5]};

   always_ff @(posedge axis_data_clk) begin
      if (axis_data_rst) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         sample_q   <= '0;
         last_q     <= 1'b0;
         sop_q      <= 1'b1;
         sps_act_q  <= CNT_W'(DEFAULT_SPS);
         mode_act_q <= 1'b0;
         pkt_cnt_q  <= '0;
         sps_reg_q  <= CNT_W'(DEFAULT_SPS);
         mode_q     <= 1'b0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         sample_q   <= sample_d;
         last_q     <= last_d;
         sop_q      <= sop_d;
         sps_act_q  <= sps_act_d;
         mode_act_q <= mode_act_d;
         pkt_cnt_q  <= pkt_cnt_d;
         sps_reg_q  <= sps_reg_d;
         mode_q     <= mode_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
      end
   end

   assign s_in.tready          = in_ready_c;
   assign m_out.tvalid         = out_valid_c;
   assign m_out.tdata          = (out_valid_c && (phase_q == '0 || mode_act_q)) ? sample_q : '0;
   assign m_out.tlast          = out_valid_c && last_q && last_phase_c;
   assign s_ctrlport.resp_ack  = ack_q;
   assign s_ctrlport.resp_data = rdata_q;

endmodule

// File: tb/tb_pulse_shape_upsampler.sv
// Randomized scoreboard bench for pulse_shape_upsampler against a per-symbol reference model.
module tb_pulse_shape_upsampler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pulse_shape_upsampler_axis_if #(.ITEM_W(32)) in_if ();
   pulse_shape_upsampler_axis_if #(.ITEM_W(32)) out_if ();
   pulse_shape_upsampler_ctrl_if cp ();

   pulse_shape_upsampler #(
      .ITEM_W(32), .MAX_SPS(16), .DEFAULT_SPS(4), .REG_BASE(20'h0)
   ) dut (
      .axis_data_clk (clk),
      .axis_data_rst (rst),
      .s_ctrlport    (cp),
      .s_in          (in_if),
      .m_out         (out_if)
   );

   typedef struct {
      logic [31:0] d;
      logic        l;
   } beat_t;

   beat_t sb[$];

   // Reference model state: programmed value, packet-latched value, packet-start flag
   int   m_sps = 4;
   bit   m_mode = 1'b0;
   bit   m_sop = 1'b1;
   int   a_sps = 4;
   bit   a_mode = 1'b0;
   int   m_pkts = 0;

   bit   rand_rdy = 1'b0;
   bit   t3_active = 1'b0;
   int   t3_first_acc = -1;
   int   t3_first_out = -1;
   int   t3_last_out = -1;
   int   t3_cnt = 0;

   bit          prev_stall = 1'b0;
   logic [32:0] prev_beat = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Input-side model: each accepted symbol expands into its expected output beats
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         m_sps  = 4;
         m_mode = 1'b0;
         m_sop  = 1'b1;
         m_pkts = 0;
      end else begin
         if (in_if.tvalid && in_if.tready) begin
            if (m_sop) begin
               a_sps  = m_sps;
               a_mode = m_mode;
            end
            for (int k = 0; k < a_sps; k++) begin
               beat_t b;
               b.d = (k == 0 || a_mode) ? in_if.tdata : 32'h0;
               b.l = in_if.tlast && (k == a_sps - 1);
               sb.push_back(b);
            end
            m_sop = in_if.tlast;
            if (in_if.tlast) m_pkts++;
            if (t3_active && t3_first_acc < 0) t3_first_acc = cyc;
         end
         if (cp.req_wr && cp.req_addr == 20'h0) begin
            m_mode = cp.req_data[8];
            if (cp.req_data[4:0] >= 5'd1 && cp.req_data[4:0] <= 5'd16) m_sps = int'(cp.req_data[4:0]);
         end
      end
   end

   // Output monitor: pops the scoreboard on every transferred beat, checks stall stability
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", 64'(out_if.tvalid), 64'd1);
            check("stall_beat_held", 64'({out_if.tlast, out_if.tdata}), 64'(prev_beat));
         end
         if (out_if.tvalid && out_if.tready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data 0x%0h with empty scoreboard (cycle %0d)",
                        out_if.tdata, cyc);
            end else begin
               beat_t e;
               e = sb.pop_front();
               check("out_data", 64'(out_if.tdata), 64'(e.d));
               check("out_last", 64'(out_if.tlast), 64'(e.l));
            end
            if (t3_active) begin
               if (t3_cnt == 0) t3_first_out = cyc;
               t3_last_out = cyc;
               t3_cnt++;
            end
         end
         prev_stall = out_if.tvalid && !out_if.tready;
         prev_beat  = {out_if.tlast, out_if.tdata};
      end
   end

   // Output backpressure generator
   always begin
      @(posedge clk);
      #1;
      out_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic ctrl_write(input logic [19:0] a, input logic [31:0] d);
      cp.req_wr = 1'b1;
      cp.req_addr = a;
      cp.req_data = d;
      @(posedge clk); #1;
      cp.req_wr = 1'b0;
      @(negedge clk);
      check("wr_ack", 64'(cp.resp_ack), 64'd1);
      check("wr_ack_data_zero", 64'(cp.resp_data), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic ctrl_read(input logic [19:0] a, output logic [31:0] v);
      cp.req_rd = 1'b1;
      cp.req_addr = a;
      @(posedge clk); #1;
      cp.req_rd = 1'b0;
      @(negedge clk);
      check("rd_ack", 64'(cp.resp_ack), 64'd1);
      v = cp.resp_data;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int t;
      t = 0;
      in_if.tdata  = d;
      in_if.tlast  = l;
      in_if.tvalid = 1'b1;
      @(negedge clk);
      while (!in_if.tready && t < 4000) begin
         t++;
         @(negedge clk);
      end
      if (t >= 4000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: tready stayed 0 for %0d cycles, required 1", t);
      end
      @(posedge clk); #1;
      in_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      @(negedge clk);
      while ((sb.size() != 0 || out_if.tvalid) && t < 4000) begin
         t++;
         @(negedge clk);
      end
      check("drain_sb_empty", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   logic [31:0] v;

   initial begin
      in_if.tvalid = 1'b0;
      in_if.tdata  = '0;
      in_if.tlast  = 1'b0;
      out_if.tready = 1'b1;
      cp.req_wr   = 1'b0;
      cp.req_rd   = 1'b0;
      cp.req_addr = '0;
      cp.req_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_tready", 64'(in_if.tready), 64'd0);
      check("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
      check("rst_out_tdata", 64'(out_if.tdata), 64'd0);
      check("rst_resp_ack", 64'(cp.resp_ack), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ctrl_read(20'h0, v);
      check("rst_ctrl_default", 64'(v), 64'h4);
      ctrl_read(20'h4, v);
      check("rst_pkt_cnt", 64'(v), 64'h0);

      // T1: zero-stuff SPS=4, two-symbol packet
      ctrl_write(20'h0, 32'h0000_0004);
      send(32'hAAAA_1111, 1'b0);
      send(32'hBBBB_2222, 1'b1);
      drain();
      ctrl_read(20'h4, v);
      check("t1_pkt_cnt", 64'(v), 64'd1);

      // T2: repeat mode SPS=3
      ctrl_write(20'h0, 32'h0000_0103);
      send(32'h7FFF_8001, 1'b1);
      drain();

      // T3: SPS=1 continuous stream, full rate and 1-cycle latency
      ctrl_write(20'h0, 32'h0000_0001);
      t3_active = 1'b1;
      for (int i = 0; i < 100; i++) send(32'h1000_0000 + 32'(i), i == 99);
      drain();
      t3_active = 1'b0;
      check("t3_out_count", 64'(t3_cnt), 64'd100);
      check("t3_consecutive", 64'(t3_last_out - t3_first_out), 64'd99);
      check("t3_latency", 64'(t3_first_out - t3_first_acc), 64'd1);

      // T4: mid-packet SPS change is deferred to the next packet
      ctrl_write(20'h0, 32'h0000_0002);
      fork
         begin
            send(32'h1111_0001, 1'b0);
            send(32'h2222_0002, 1'b1);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            ctrl_write(20'h0, 32'h0000_0008);
            ctrl_read(20'h0, v);
            check("t4_ctrl_readback", 64'(v), 64'h8);
         end
      join
      send(32'h3333_0003, 1'b1);
      drain();

      // T5: illegal SPS writes, MODE-only update, RO and unmapped registers
      ctrl_write(20'h0, 32'h0000_0000);
      ctrl_read(20'h0, v);
      check("t5_sps0_ignored", 64'(v), 64'h8);
      ctrl_write(20'h0, 32'h0000_0011);
      ctrl_read(20'h0, v);
      check("t5_sps17_ignored", 64'(v), 64'h8);
      ctrl_write(20'h0, 32'h0000_0100);
      ctrl_read(20'h0, v);
      check("t5_mode_only", 64'(v), 64'h108);
      ctrl_write(20'h4, 32'hDEAD_BEEF);
      ctrl_read(20'h4, v);
      check("t5_pkt_cnt_ro", 64'(v), 64'(m_pkts));
      ctrl_read(20'h8, v);
      check("t5_unmapped_rd", 64'(v), 64'h0);

      // T6: random packets, random CTRL, random backpressure and input gaps
      rand_rdy = 1'b1;
      for (int p = 0; p < 30; p++) begin
         int len;
         if ($urandom_range(0, 2) == 0)
            ctrl_write(20'h0, {23'd0, 1'($urandom_range(0, 1)), 3'd0, 5'($urandom_range(0, 18))});
         len = int'($urandom_range(1, 4));
         for (int s = 0; s < len; s++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
               @(posedge clk); #1;
            end
            send($urandom, s == len - 1);
         end
      end
      drain();
      rand_rdy = 1'b0;
      ctrl_read(20'h4, v);
      check("t6_pkt_cnt", 64'(v), 64'(m_pkts));

      // Reset in the middle of a burst discards the in-flight sample
      ctrl_write(20'h0, 32'h0000_0008);
      send(32'hABCD_0001, 1'b1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_in_tready", 64'(in_if.tready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_tvalid", 64'(out_if.tvalid), 64'd0);
      @(posedge clk); #1;
      ctrl_read(20'h0, v);
      check("midrst_ctrl_default", 64'(v), 64'h4);
      ctrl_read(20'h4, v);
      check("midrst_pkt_cnt", 64'(v), 64'h0);
      check("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

endmodule
